// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes the ID instruction into a control bundle, carries it
// through EX/MEM/WB, and resolves load-use and MULT/DIV hazards with bubbles and stall_if.
module ctrl_pipe_unit #(
    parameter int         ALU_W      = 5,
    parameter int         MULDIV_LAT = 4,
    parameter logic [4:0] LINK_REG   = 5'd31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       op_code,
    input  logic [5:0]       funct_code,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             stall_if,
    output logic             illegal_instr,
    output logic             muldiv_busy,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_jal,
    output logic             ex_load_upper,
    output logic [1:0]       ex_jump,
    output logic [3:0]       ex_bcu_control,
    output logic [ALU_W-1:0] ex_alu_control,
    output logic [4:0]       ex_dest,
    output logic             mem_valid,
    output logic             mem_reg_write,
    output logic             mem_mem_to_reg,
    output logic             mem_mem_write,
    output logic [4:0]       mem_dest,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [4:0]       wb_dest
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_ADDU  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SUBU  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_NOR   = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(10);
    localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(11);
    localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(12);
    localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(13);
    localparam logic [ALU_W-1:0] ALU_SLLV  = ALU_W'(14);
    localparam logic [ALU_W-1:0] ALU_SRLV  = ALU_W'(15);
    localparam logic [ALU_W-1:0] ALU_SRAV  = ALU_W'(16);
    localparam logic [ALU_W-1:0] ALU_LUI   = ALU_W'(17);
    localparam logic [ALU_W-1:0] ALU_MULT  = ALU_W'(18);
    localparam logic [ALU_W-1:0] ALU_MULTU = ALU_W'(19);
    localparam logic [ALU_W-1:0] ALU_DIV   = ALU_W'(20);
    localparam logic [ALU_W-1:0] ALU_DIVU  = ALU_W'(21);
    localparam logic [ALU_W-1:0] ALU_MFHI  = ALU_W'(22);
    localparam logic [ALU_W-1:0] ALU_MFLO  = ALU_W'(23);
    localparam logic [ALU_W-1:0] ALU_UNDEF = ALU_W'(31);

    localparam logic [3:0] BCU_BEQ = 4'b0001;
    localparam logic [3:0] BCU_BNE = 4'b0010;

    localparam logic [3:0] C_MD_LAT = 4'(MULDIV_LAT);

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             branch;
        logic             jal;
        logic             load_upper;
        logic [1:0]       jump;
        logic [3:0]       bcu;
        logic [ALU_W-1:0] alu;
        logic [4:0]       dest;
        logic             illegal;
    } ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [4:0] dest;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] dest;
    } wb_t;

    localparam ctrl_t C_BUBBLE = '{alu: ALU_UNDEF, default: '0};

    ctrl_t      w_dec;
    logic       w_bad;
    logic       w_rt_read;
    logic       w_is_muldiv;
    logic       w_is_hilo;
    logic       w_load_hazard;
    logic       w_muldiv_hazard;
    logic       w_ex_load;

    ctrl_t      r_ex;
    logic       r_ex_valid;
    mem_t       r_mem;
    wb_t        r_wb;
    logic [3:0] r_md_cnt;

    always_comb begin : decode
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_dec       = C_BUBBLE;
        w_bad       = 1'b0;
        w_rt_read   = 1'b0;
        w_is_muldiv = 1'b0;
        w_is_hilo   = 1'b0;
        case (op_code)
            OP_SPECIAL: begin
                w_rt_read       = 1'b1;
                w_dec.reg_write = 1'b1;
                case (funct_code)
                    F_SLL:   w_dec.alu = ALU_SLL;
                    F_SRL:   w_dec.alu = ALU_SRL;
                    F_SRA:   w_dec.alu = ALU_SRA;
                    F_SLLV:  w_dec.alu = ALU_SLLV;
                    F_SRLV:  w_dec.alu = ALU_SRLV;
                    F_SRAV:  w_dec.alu = ALU_SRAV;
                    F_JR:    begin w_dec.reg_write = 1'b0; w_dec.jump = 2'b10; end
                    F_MFHI:  begin w_dec.alu = ALU_MFHI; w_is_hilo = 1'b1; end
                    F_MFLO:  begin w_dec.alu = ALU_MFLO; w_is_hilo = 1'b1; end
                    F_MULT:  begin w_dec.reg_write = 1'b0; w_dec.alu = ALU_MULT;  w_is_muldiv = 1'b1; end
                    F_MULTU: begin w_dec.reg_write = 1'b0; w_dec.alu = ALU_MULTU; w_is_muldiv = 1'b1; end
                    F_DIV:   begin w_dec.reg_write = 1'b0; w_dec.alu = ALU_DIV;   w_is_muldiv = 1'b1; end
                    F_DIVU:  begin w_dec.reg_write = 1'b0; w_dec.alu = ALU_DIVU;  w_is_muldiv = 1'b1; end
                    F_ADD:   w_dec.alu = ALU_ADD;
                    F_ADDU:  w_dec.alu = ALU_ADDU;
                    F_SUB:   w_dec.alu = ALU_SUB;
                    F_SUBU:  w_dec.alu = ALU_SUBU;
                    F_AND:   w_dec.alu = ALU_AND;
                    F_OR:    w_dec.alu = ALU_OR;
                    F_XOR:   w_dec.alu = ALU_XOR;
                    F_NOR:   w_dec.alu = ALU_NOR;
                    F_SLT:   w_dec.alu = ALU_SLT;
                    F_SLTU:  w_dec.alu = ALU_SLTU;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_J:     w_dec.jump = 2'b01;
            OP_JAL:   begin w_dec.jump = 2'b01; w_dec.jal = 1'b1; w_dec.reg_write = 1'b1; end
            OP_BEQ:   begin w_rt_read = 1'b1; w_dec.branch = 1'b1; w_dec.bcu = BCU_BEQ; w_dec.alu = ALU_SUB; end
            OP_BNE:   begin w_rt_read = 1'b1; w_dec.branch = 1'b1; w_dec.bcu = BCU_BNE; w_dec.alu = ALU_SUB; end
            OP_ADDI:  begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_ADD;  end
            OP_ADDIU: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_ADDU; end
            OP_SLTI:  begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_SLT;  end
            OP_SLTIU: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_SLTU; end
            OP_ANDI:  begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_AND;  end
            OP_ORI:   begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_OR;   end
            OP_XORI:  begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_XOR;  end
            OP_LUI:   begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.load_upper = 1'b1;
                w_dec.alu        = ALU_LUI;
            end
            OP_LW:    begin
                w_dec.reg_write  = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.alu        = ALU_ADD;
            end
            OP_SW:    begin
                w_rt_read       = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu       = ALU_ADD;
            end
            default:  w_bad = 1'b1;
        endcase

        // An undecodable instruction keeps only its illegal flag; nothing may write.
        if (w_bad) begin
            w_dec         = C_BUBBLE;
            w_dec.illegal = 1'b1;
        end

        if (op_code == OP_SPECIAL)  w_dec.dest = rd;
        else if (op_code == OP_JAL) w_dec.dest = LINK_REG;
        else                        w_dec.dest = rt;

        if (w_dec.dest == 5'd0) w_dec.reg_write = 1'b0;
    end

    assign muldiv_busy     = (r_md_cnt != 4'd0);
    assign w_load_hazard   = id_valid & r_ex_valid & r_ex.mem_to_reg & (r_ex.dest != 5'd0) &
                             ((r_ex.dest == rs) | (w_rt_read & (r_ex.dest == rt)));
    assign w_muldiv_hazard = id_valid & muldiv_busy & (w_is_muldiv | w_is_hilo);
    assign stall_if        = w_load_hazard | w_muldiv_hazard | ext_stall;
    assign w_ex_load       = id_valid & ~flush & ~w_load_hazard & ~w_muldiv_hazard;

    // ext_stall freezes everything except the flush kill of EX; the counter ignores flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
            r_ex_valid <= 1'b0;
            r_ex       <= C_BUBBLE;
            r_mem      <= '0;
            r_wb       <= '0;
            r_md_cnt   <= '0;
        end else if (ext_stall) begin
            if (flush) begin
                r_ex_valid <= 1'b0;
                r_ex       <= C_BUBBLE;
            end
        end else begin
            r_mem <= '{valid: r_ex_valid, reg_write: r_ex.reg_write, mem_to_reg: r_ex.mem_to_reg,
                       mem_write: r_ex.mem_write, dest: r_ex.dest};
            r_wb  <= '{valid: r_mem.valid, reg_write: r_mem.reg_write,
                       mem_to_reg: r_mem.mem_to_reg, dest: r_mem.dest};
            if (w_ex_load) begin
                r_ex_valid <= 1'b1;
                r_ex       <= w_dec;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex       <= C_BUBBLE;
            end
            if (w_ex_load && w_is_muldiv) r_md_cnt <= C_MD_LAT;
            else if (r_md_cnt != 4'd0)    r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ex_reg_write   = r_ex.reg_write;
    assign ex_mem_to_reg  = r_ex.mem_to_reg;
    assign ex_mem_write   = r_ex.mem_write;
    assign ex_alu_src     = r_ex.alu_src;
    assign ex_branch      = r_ex.branch;
    assign ex_jal         = r_ex.jal;
    assign ex_load_upper  = r_ex.load_upper;
    assign ex_jump        = r_ex.jump;
    assign ex_bcu_control = r_ex.bcu;
    assign ex_alu_control = r_ex.alu;
    assign ex_dest        = r_ex.dest;
    assign illegal_instr  = r_ex.illegal;

    assign mem_valid      = r_mem.valid;
    assign mem_reg_write  = r_mem.reg_write;
    assign mem_mem_to_reg = r_mem.mem_to_reg;
    assign mem_mem_write  = r_mem.mem_write;
    assign mem_dest       = r_mem.dest;

    assign wb_valid       = r_wb.valid;
    assign wb_reg_write   = r_wb.reg_write;
    assign wb_mem_to_reg  = r_wb.mem_to_reg;
    assign wb_dest        = r_wb.dest;

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Successor to the combinational decoder. Decodes op_code/funct_code in ID into a control bundle and registers it through ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Tracks a parametrised multi-cycle MULT/DIV unit and applies flush/stall.
- Sits between the IF/ID register and the datapath. Drives stall_if back to the PC and IF/ID.

Parameters:
- ALU_W, 5, width of alu_control; codes are the ALU_* macros from ManBearPig.h.
- MULDIV_LAT, 4, cycles MULT/DIV occupies HI/LO; legal range 2..15.
- LINK_REG, 31, destination register for JAL.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- op_code  in  6  instruction [31:26]
- funct_code  in  6  instruction [5:0]
- rs, rt, rd  in  5 each  register fields
- ext_stall  in  1  global freeze (memory wait)
- flush  in  1  branch/jump resolved taken; kill ID instruction
- stall_if  out  1  hold PC and IF/ID this cycle
- illegal_instr  out  1  registered; pulses with ex_valid for an undecodable instruction
- muldiv_busy  out  1  HI/LO result pending
- ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_branch, ex_jal, ex_load_upper  out  1 each
- ex_jump  out  2  00 none, 01 J/JAL, 10 JR
- ex_bcu_control  out  4  BEQ/BNE compare selector
- ex_alu_control  out  ALU_W
- ex_dest  out  5
- mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_write  out  1 each
- mem_dest  out  5
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each
- wb_dest  out  5

Behaviour:
- Reset: every output register is 0; ex_alu_control = ALU_undef; muldiv counter = 0.
- Reset is asynchronous and takes effect mid-stall or mid-MULT/DIV with no residue.
- Decode is combinational, same mapping as the existing control unit, plus:
  - MULT/MULTU/DIV/DIVU (funct 0x18..0x1B): no reg_write.
  - MFHI/MFLO (0x10/0x12): reg_write = 1, dest = rd.
- dest selection: SPECIAL uses rd, JAL uses LINK_REG, everything else uses rt.
- reg_write is forced to 0 whenever dest = 0.
- Unknown opcode/funct:
  - all write and memory enables are 0; alu_control = ALU_undef.
  - illegal_instr = 1 in the EX cycle for that instruction.
- Latency: the decoded bundle appears on ex_* 1 cycle after ID, on mem_* after 2, on wb_* after 3.
- Register-use rule: rs is always treated as read. rt is read by SPECIAL, BEQ, BNE and SW.
- load_hazard = id_valid & ex_valid & ex_mem_to_reg & ex_dest != 0 & (ex_dest == rs | (rt read & ex_dest == rt)).
- muldiv_hazard = id_valid & muldiv_busy & ID is MULT/DIV/MFHI/MFLO.
- stall_if = load_hazard | muldiv_hazard | ext_stall.
- Per-cycle priority, highest first:
  1. ext_stall: all stage registers hold and the counter holds. If flush is also high, EX is still cleared to a bubble.
  2. flush: EX loads a bubble (valid and all enables 0); MEM and WB advance.
  3. hazard: EX loads a bubble; MEM and WB advance; ID is held via stall_if.
  4. Otherwise EX loads the decoded bundle, qualified by id_valid. id_valid = 0 loads a bubble.
- Bubbles carry dest = 0 and alu_control = ALU_undef.
- MULT/DIV counter:
  - Loads MULDIV_LAT when a valid MULT/DIV enters EX.
  - Decrements each non-ext_stall cycle while nonzero.
  - muldiv_busy = (counter != 0).
  - A MULT/DIV and an MFLO in back-to-back slots: MFLO stalls exactly MULDIV_LAT cycles.
- flush never cancels an in-flight MULT/DIV already in EX or beyond.

Test Plan:
- Reset: assert rst asynchronously between edges → all valid/enable outputs 0 immediately; ex_alu_control = ALU_undef.
- LW $8 followed by ADD $9,$8,$1 → 1 bubble on ex_valid, stall_if high 1 cycle; ADD reaches EX one cycle late. Repeat with LW writing $0 → no stall.
- ADDI to $0 → ex_reg_write = 0. JAL → ex_dest = 31, ex_jal = 1, ex_jump = 01, then mem_dest = 31, wb_dest = 31 on the following cycles.
- MULT then MFLO, MULDIV_LAT = 4 → stall_if high 4 cycles, muldiv_busy counts down, MFLO enters EX on cycle 5. ext_stall held 2 cycles mid-count → total stall 6.
- flush together with a load-use hazard → EX bubble, MEM/WB advance; flush plus ext_stall → EX cleared, MEM/WB frozen.
- Opcode 0x3F → illegal_instr pulses 1 cycle; no reg_write or mem_write at any stage.
